// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard/forwarding controller.
//   fwd_sel_e  : EX-stage operand mux select encoding
//   hz_state_e : hazard controller FSM states
//   STAGE_*    : values of the BR_STAGE parameter
package riscv_pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        S_RUN,
        S_LU_STALL,
        S_FREEZE
    } hz_state_e;

    localparam int unsigned STAGE_EX  = 2;
    localparam int unsigned STAGE_MEM = 3;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// Forwarding select for one EX-stage operand.
//   rs                     : source register of the ID_EX instruction
//   mem_rd / mem_regwrite  : EX_MEM destination and write flag
//   wb_rd  / wb_regwrite   : MEM_WB destination and write flag
//   sel                    : FWD_MEM, FWD_WB or FWD_RF (x0 is never forwarded)
module fwd_sel
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW = 5
) (
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    output fwd_sel_e          sel
);

    always_comb begin
        sel = FWD_RF;
        // EX_MEM holds the younger result, so it wins over MEM_WB
        if (mem_regwrite && (mem_rd != '0) && (mem_rd == rs))
            sel = FWD_MEM;
        else if (wb_regwrite && (wb_rd != '0) && (wb_rd == rs))
            sel = FWD_WB;
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / forwarding controller for a 5-stage RISC-V pipeline.
//   Inputs : reset (async, active-low), ID/EX/MEM/WB register indices and
//            control flags, br_taken (resolved in stage BR_STAGE), dmem_busy.
//   Outputs: forward_a/forward_b operand selects, stage write enables,
//            stage flushes, saturating stall_cnt / flush_cnt.
// Priority each cycle: dmem_busy > br_taken > load-use stall.
module pipe_hazard_ctrl
    import riscv_pipe_pkg::*;
#(
    parameter int unsigned REG_AW   = 5,
    parameter int unsigned LOAD_LAT = 1,
    parameter int unsigned BR_STAGE = 3,
    parameter int unsigned CNT_W    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              br_taken,
    input  logic              dmem_busy,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              ex_mem_write,
    output logic              mem_wb_write,
    output logic              if_id_flush,
    output logic              id_ex_flush,
    output logic              ex_mem_flush,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic       BR_IN_MEM = (BR_STAGE == STAGE_MEM);
    localparam logic [2:0] LU_INIT   = 3'(LOAD_LAT - 1);

    hz_state_e  state, state_nx;
    logic [2:0] lu_cnt, lu_nx;
    logic       br_pend, pend_nx;
    logic       lu_hit, resume_lu, flush_go;
    fwd_sel_e   sel_a, sel_b;

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_a (
        .rs(ex_rs1), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_a)
    );

    fwd_sel #(.REG_AW(REG_AW)) u_fwd_b (
        .rs(ex_rs2), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .sel(sel_b)
    );

    assign lu_hit = ex_memread && (ex_rd != '0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) ||
                     (id_rs2_used && (id_rs2 == ex_rd)));

    // Leaving S_FREEZE, the release cycle already behaves as the state we
    // return to, so a saved load-use count resumes without losing a cycle.
    assign resume_lu = (state == S_LU_STALL) ||
                       ((state == S_FREEZE) && (lu_cnt != '0));

    always_comb begin
        forward_a    = sel_a;
        forward_b    = sel_b;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        ex_mem_write = 1'b1;
        mem_wb_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        flush_go     = 1'b0;
        state_nx     = S_RUN;
        lu_nx        = lu_cnt;
        pend_nx      = 1'b0;

        if (dmem_busy) begin
            // whole pipe frozen; a branch seen now is remembered, lu_cnt held
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            state_nx     = S_FREEZE;
            pend_nx      = br_pend | br_taken;
        end else if (br_taken || ((state == S_FREEZE) && br_pend)) begin
            // branch flush also aborts any load-use stall in progress
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = BR_IN_MEM;
            flush_go     = 1'b1;
            lu_nx        = '0;
        end else if (resume_lu) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            lu_nx        = lu_cnt - 3'd1;
            state_nx     = (lu_cnt <= 3'd1) ? S_RUN : S_LU_STALL;
        end else if (lu_hit) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_flush  = 1'b1;
            lu_nx        = LU_INIT;
            state_nx     = (LOAD_LAT > 1) ? S_LU_STALL : S_RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_RUN;
            lu_cnt    <= '0;
            br_pend   <= 1'b0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state   <= state_nx;
            lu_cnt  <= lu_nx;
            br_pend <= pend_nx;
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_go && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
//   u_d1 : LOAD_LAT=1, BR_STAGE=3 (MEM), CNT_W=32
//   u_d3 : LOAD_LAT=3, BR_STAGE=2 (EX),  CNT_W=4
// Control vector order: {pc_write, if_id_write, ex_mem_write, mem_wb_write,
//                        if_id_flush, id_ex_flush, ex_mem_flush}
module tb_pipe_hazard_ctrl;

    localparam logic [6:0] C_RUN   = 7'b1111_000;
    localparam logic [6:0] C_STALL = 7'b0011_010;
    localparam logic [6:0] C_FRZ   = 7'b0000_000;
    localparam logic [6:0] C_FL3   = 7'b1111_111;
    localparam logic [6:0] C_FL2   = 7'b1111_110;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rs1 = '0, ex_rs2 = '0, ex_rd = '0;
    logic [4:0] mem_rd = '0, wb_rd = '0;
    logic       id_rs1_used = 1'b0, id_rs2_used = 1'b0, ex_memread = 1'b0;
    logic       mem_regwrite = 1'b0, wb_regwrite = 1'b0, br_taken = 1'b0, dmem_busy = 1'b0;

    logic [1:0]  fa1, fb1, fa3, fb3;
    logic        pw1, iw1, ew1, mw1, iff1, idf1, emf1;
    logic        pw3, iw3, ew3, mw3, iff3, idf3, emf3;
    logic [31:0] sc1, fc1;
    logic [3:0]  sc3, fc3;
    logic [6:0]  ctl1, ctl3;

    int n_cmp = 0;
    int n_err = 0;

    assign ctl1 = {pw1, iw1, ew1, mw1, iff1, idf1, emf1};
    assign ctl3 = {pw3, iw3, ew3, mw3, iff3, idf3, emf3};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(1), .BR_STAGE(3), .CNT_W(32)) u_d1 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .br_taken(br_taken), .dmem_busy(dmem_busy), .forward_a(fa1), .forward_b(fb1),
        .pc_write(pw1), .if_id_write(iw1), .ex_mem_write(ew1), .mem_wb_write(mw1),
        .if_id_flush(iff1), .id_ex_flush(idf1), .ex_mem_flush(emf1),
        .stall_cnt(sc1), .flush_cnt(fc1)
    );

    pipe_hazard_ctrl #(.REG_AW(5), .LOAD_LAT(3), .BR_STAGE(2), .CNT_W(4)) u_d3 (
        .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
        .br_taken(br_taken), .dmem_busy(dmem_busy), .forward_a(fa3), .forward_b(fb3),
        .pc_write(pw3), .if_id_write(iw3), .ex_mem_write(ew3), .mem_wb_write(mw3),
        .if_id_flush(iff3), .id_ex_flush(idf3), .ex_mem_flush(emf3),
        .stall_cnt(sc3), .flush_cnt(fc3)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_hit(input logic on);
        ex_memread  = on;
        ex_rd       = on ? 5'd7 : 5'd0;
        id_rs2      = on ? 5'd7 : 5'd0;
        id_rs2_used = on;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_RUN || ctl3 !== C_RUN) begin
            n_err++;
            $display("FAIL reset_ctl: got d1=%b d3=%b want %b", ctl1, ctl3, C_RUN);
        end
        n_cmp++;
        if (sc1 !== 32'd0 || fc1 !== 32'd0 || sc3 !== 4'd0 || fc3 !== 4'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d %0d %0d %0d want 0", sc1, fc1, sc3, fc3);
        end
        n_cmp++;
        if (fa1 !== 2'b00 || fb1 !== 2'b00) begin
            n_err++;
            $display("FAIL reset_fwd: got a=%b b=%b want 00", fa1, fb1);
        end
        next_cycle();
        reset = 1'b1;
    endtask

    task automatic test_forward();
        mem_rd = 5'd5; mem_regwrite = 1'b1; wb_rd = 5'd5; wb_regwrite = 1'b1; ex_rs1 = 5'd5;
        @(negedge clk);
        n_cmp++;
        if (fa1 !== 2'b10 || fa3 !== 2'b10) begin
            n_err++;
            $display("FAIL fwd_mem_wins: got %b/%b want 10", fa1, fa3);
        end
        mem_regwrite = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (fa1 !== 2'b01) begin
            n_err++;
            $display("FAIL fwd_wb: got %b want 01", fa1);
        end
        wb_rd = 5'd0; ex_rs2 = 5'd0; ex_rs1 = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (fb1 !== 2'b00 || fa1 !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_x0: got a=%b b=%b want 00", fa1, fb1);
        end
        mem_rd = 5'd9; mem_regwrite = 1'b1; ex_rs2 = 5'd9; wb_rd = 5'd9;
        @(negedge clk);
        n_cmp++;
        if (fb1 !== 2'b10 || fa1 !== 2'b00) begin
            n_err++;
            $display("FAIL fwd_b_mem: got a=%b b=%b want a=00 b=10", fa1, fb1);
        end
        mem_rd = '0; mem_regwrite = 1'b0; wb_rd = '0; wb_regwrite = 1'b0; ex_rs2 = '0;
        next_cycle();
    endtask

    task automatic test_load_use();
        logic [6:0] e3;
        set_hit(1'b1);
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_STALL || ctl3 !== C_STALL) begin
            n_err++;
            $display("FAIL lu_c0: got d1=%b d3=%b want %b", ctl1, ctl3, C_STALL);
        end
        next_cycle();
        set_hit(1'b0);
        for (int i = 1; i < 5; i++) begin
            e3 = (i < 3) ? C_STALL : C_RUN;
            @(negedge clk);
            n_cmp++;
            if (ctl1 !== C_RUN || ctl3 !== e3) begin
                n_err++;
                $display("FAIL lu_c%0d: got d1=%b d3=%b want d1=%b d3=%b", i, ctl1, ctl3, C_RUN, e3);
            end
            next_cycle();
        end
        n_cmp++;
        if (sc1 !== 32'd1 || sc3 !== 4'd3) begin
            n_err++;
            $display("FAIL lu_stall_cnt: got %0d/%0d want 1/3", sc1, sc3);
        end
        set_hit(1'b1);
        id_rs2_used = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_RUN || ctl3 !== C_RUN) begin
            n_err++;
            $display("FAIL lu_unused: got d1=%b d3=%b want %b", ctl1, ctl3, C_RUN);
        end
        id_rs2_used = 1'b1; ex_rd = 5'd0; id_rs2 = 5'd0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_RUN || ctl3 !== C_RUN) begin
            n_err++;
            $display("FAIL lu_x0: got d1=%b d3=%b want %b", ctl1, ctl3, C_RUN);
        end
        set_hit(1'b0);
        next_cycle();
    endtask

    task automatic test_branch();
        br_taken = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_FL3 || ctl3 !== C_FL2) begin
            n_err++;
            $display("FAIL br_flush: got d1=%b d3=%b want %b/%b", ctl1, ctl3, C_FL3, C_FL2);
        end
        next_cycle();
        br_taken = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_RUN || ctl3 !== C_RUN || fc1 !== 32'd1 || fc3 !== 4'd1) begin
            n_err++;
            $display("FAIL br_after: got d1=%b d3=%b fc=%0d/%0d want %b fc=1/1",
                     ctl1, ctl3, fc1, fc3, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_freeze_branch();
        dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            br_taken = (i == 1);
            @(negedge clk);
            n_cmp++;
            if (ctl1 !== C_FRZ || ctl3 !== C_FRZ) begin
                n_err++;
                $display("FAIL frz_c%0d: got d1=%b d3=%b want %b", i, ctl1, ctl3, C_FRZ);
            end
            next_cycle();
        end
        dmem_busy = 1'b0;
        br_taken  = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_FL3 || ctl3 !== C_FL2) begin
            n_err++;
            $display("FAIL frz_release: got d1=%b d3=%b want %b/%b", ctl1, ctl3, C_FL3, C_FL2);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (ctl1 !== C_RUN || fc1 !== 32'd2 || fc3 !== 4'd2 || sc1 !== 32'd5 || sc3 !== 4'd7) begin
            n_err++;
            $display("FAIL frz_cnt: got ctl=%b fc=%0d/%0d sc=%0d/%0d want %b fc=2/2 sc=5/7",
                     ctl1, fc1, fc3, sc1, sc3, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_freeze_resume();
        logic [6:0] e1 [6];
        logic [6:0] e3 [6];
        e1 = '{C_STALL, C_FRZ, C_FRZ, C_RUN,   C_RUN,   C_RUN};
        e3 = '{C_STALL, C_FRZ, C_FRZ, C_STALL, C_STALL, C_RUN};
        for (int i = 0; i < 6; i++) begin
            set_hit(i == 0);
            dmem_busy = (i == 1) || (i == 2);
            @(negedge clk);
            n_cmp++;
            if (ctl1 !== e1[i] || ctl3 !== e3[i]) begin
                n_err++;
                $display("FAIL resume_c%0d: got d1=%b d3=%b want d1=%b d3=%b",
                         i, ctl1, ctl3, e1[i], e3[i]);
            end
            next_cycle();
        end
        dmem_busy = 1'b0;
        n_cmp++;
        if (sc1 !== 32'd8 || sc3 !== 4'd12) begin
            n_err++;
            $display("FAIL resume_cnt: got %0d/%0d want 8/12", sc1, sc3);
        end
    endtask

    task automatic test_reset_mid_stall();
        set_hit(1'b1);
        next_cycle();
        set_hit(1'b0);
        @(negedge clk);
        n_cmp++;
        if (ctl3 !== C_STALL) begin
            n_err++;
            $display("FAIL rst_pre: got d3=%b want %b", ctl3, C_STALL);
        end
        #1 reset = 1'b0;
        #1;
        n_cmp++;
        if (ctl3 !== C_RUN || sc1 !== 32'd0 || sc3 !== 4'd0 || fc1 !== 32'd0 || fc3 !== 4'd0) begin
            n_err++;
            $display("FAIL rst_mid: got d3=%b sc=%0d/%0d fc=%0d/%0d want %b all 0",
                     ctl3, sc1, sc3, fc1, fc3, C_RUN);
        end
        next_cycle();
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ctl3 !== C_RUN || ctl1 !== C_RUN) begin
            n_err++;
            $display("FAIL rst_after: got d1=%b d3=%b want %b", ctl1, ctl3, C_RUN);
        end
        next_cycle();
    endtask

    task automatic test_saturate();
        dmem_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1 dmem_busy = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (sc1 !== 32'd20 || sc3 !== 4'd15) begin
            n_err++;
            $display("FAIL sat_cnt: got %0d/%0d want 20/15", sc1, sc3);
        end
        next_cycle();
        @(negedge clk);
        n_cmp++;
        if (sc3 !== 4'd15 || ctl3 !== C_RUN) begin
            n_err++;
            $display("FAIL sat_hold: got sc=%0d ctl=%b want 15 %b", sc3, ctl3, C_RUN);
        end
    endtask

    initial begin
        test_reset();
        test_forward();
        test_load_use();
        test_branch();
        test_freeze_branch();
        test_freeze_resume();
        test_reset_mid_stall();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
